// File: rtl/mult_rom_reader.sv
// Initiator for a multiplication ROM: single lookups over valid/ready, plus a sweep
// mode that re-checks every ROM entry against a sequential shift-add multiplier.
module mult_rom_reader #(
  parameter int N      = 8,
  parameter int PROD_W = 2*N,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic [2*N-1:0]    mem_address,
  output logic              mem_read_en,
  output logic              mem_ce,
  input  logic [PROD_W-1:0] mem_data,
  output logic              sweep_done,
  output logic [2*N:0]      err_count,
  output logic              err_flag,
  output logic [2*N-1:0]    first_err_addr
);

  localparam int MCW = $clog2(N+1);
  localparam bit LAT0 = (RD_LAT == 0);
  localparam logic [7:0] LAT_LAST = LAT0 ? 8'd0 : 8'(RD_LAT - 1);
  localparam logic [2*N-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE, STROBE, WAIT, HOLD, SW_STROBE, SW_WAIT, SW_CHECK, SW_END
  } state_t;

  state_t state_reg, state_next;

  logic [N-1:0]      a_reg, b_reg;
  logic [2*N-1:0]    addr_reg;
  logic [7:0]        rd_cnt_reg;
  logic              rd_done_reg;
  logic [PROD_W-1:0] product_reg;
  logic [PROD_W-1:0] mc_reg, acc_reg;
  logic [N-1:0]      mp_reg;
  logic [MCW-1:0]    mul_cnt_reg;
  logic [2*N:0]      err_count_reg;
  logic              err_flag_reg;
  logic [2*N-1:0]    first_err_addr_reg;

  logic accept, sample_now, mul_done;

  assign accept   = in_valid && (state_reg == IDLE);
  assign mul_done = (mul_cnt_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (in_valid) state_next = mode ? SW_STROBE : STROBE;
      STROBE:    state_next = LAT0 ? HOLD : WAIT;
      WAIT:      if (rd_cnt_reg == LAT_LAST) state_next = HOLD;
      HOLD:      if (out_ready) state_next = IDLE;
      SW_STROBE: state_next = SW_WAIT;
      SW_WAIT:   if (rd_done_reg && mul_done) state_next = SW_CHECK;
      SW_CHECK:  state_next = (addr_reg == LAST_ADDR) ? SW_END : SW_STROBE;
      SW_END:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    mem_ce      = 1'b0;
    mem_read_en = 1'b0;
    mem_address = '0;
    sweep_done  = 1'b0;
    case (state_reg)
      IDLE:   in_ready = 1'b1;
      STROBE: begin
        mem_ce      = 1'b1;
        mem_read_en = 1'b1;
        mem_address = {a_reg, b_reg};
      end
      HOLD:   out_valid = 1'b1;
      SW_STROBE: begin
        mem_ce      = 1'b1;
        mem_read_en = 1'b1;
        mem_address = addr_reg;
      end
      SW_END: sweep_done = 1'b1;
      default: ;
    endcase
  end

  // Read data is captured once per strobe, RD_LAT edges after the strobe cycle.
  always_comb begin
    sample_now = 1'b0;
    case (state_reg)
      STROBE, SW_STROBE: sample_now = LAT0;
      WAIT:              sample_now = (rd_cnt_reg == LAT_LAST);
      SW_WAIT:           sample_now = !rd_done_reg && (rd_cnt_reg == LAT_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg              <= '0;
      b_reg              <= '0;
      addr_reg           <= '0;
      rd_cnt_reg         <= '0;
      rd_done_reg        <= 1'b0;
      product_reg        <= '0;
      mc_reg             <= '0;
      acc_reg            <= '0;
      mp_reg             <= '0;
      mul_cnt_reg        <= '0;
      err_count_reg      <= '0;
      err_flag_reg       <= 1'b0;
      first_err_addr_reg <= '0;
    end else begin
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        if (mode) begin
          addr_reg           <= '0;
          err_count_reg      <= '0;
          err_flag_reg       <= 1'b0;
          first_err_addr_reg <= '0;
        end
      end
      case (state_reg)
        STROBE: begin
          rd_cnt_reg  <= '0;
          rd_done_reg <= 1'b0;
        end
        SW_STROBE: begin
          rd_cnt_reg  <= '0;
          rd_done_reg <= 1'b0;
          mc_reg      <= PROD_W'(addr_reg[2*N-1:N]);
          mp_reg      <= addr_reg[N-1:0];
          acc_reg     <= '0;
          mul_cnt_reg <= MCW'(N);
        end
        WAIT, SW_WAIT: begin
          if (!rd_done_reg) rd_cnt_reg <= rd_cnt_reg + 8'd1;
          // Reference multiplier: one multiplier bit per cycle, LSB first.
          if (state_reg == SW_WAIT && !mul_done) begin
            if (mp_reg[0]) acc_reg <= acc_reg + mc_reg;
            mc_reg      <= mc_reg << 1;
            mp_reg      <= mp_reg >> 1;
            mul_cnt_reg <= mul_cnt_reg - 1'b1;
          end
        end
        SW_CHECK: begin
          if (product_reg != acc_reg) begin
            err_count_reg <= err_count_reg + 1'b1;
            if (!err_flag_reg) begin
              err_flag_reg       <= 1'b1;
              first_err_addr_reg <= addr_reg;
            end
          end
          if (addr_reg != LAST_ADDR) addr_reg <= addr_reg + 1'b1;
        end
        default: ;
      endcase
      if (sample_now) begin
        product_reg <= mem_data;
        rd_done_reg <= 1'b1;
      end
    end
  end

  assign product        = product_reg;
  assign err_count      = err_count_reg;
  assign err_flag       = err_flag_reg;
  assign first_err_addr = first_err_addr_reg;

endmodule
